// File: rtl/user_pair_alu.sv
// Pairing kernel: joins one word from each input stream, emits sum/difference plus a per-frame trailer.
// Optional build macro USER_PAIR_ALU_SAT_EN selects signed saturating arithmetic instead of wrap-around.

module user_pair_alu_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             ack,
   output logic [WIDTH-1:0] data,
   output logic             vld,
   output logic             room
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             pop;

   assign vld  = (count != '0);
   assign pop  = ack & vld;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign room = (count != FULL_CNT) | pop;
   assign data = vld ? mem[rd_ptr] : '0;

   // NOTE: the storage array has no reset; the count gates every read, so stale entries never leak out.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end
endmodule

module user_pair_alu #(
   parameter int PAYLOAD_BITS = 32,
   parameter int FRAME_LEN    = 16,
   parameter int OUT_DEPTH    = 2
) (
   input  logic                    clk_user,
   input  logic                    reset,
   input  logic [PAYLOAD_BITS-1:0] dout_leaf_interface2user_1,
   input  logic [PAYLOAD_BITS-1:0] dout_leaf_interface2user_2,
   input  logic                    vld_interface2user_1,
   input  logic                    vld_interface2user_2,
   output logic                    ack_user2interface_1,
   output logic                    ack_user2interface_2,
   output logic [PAYLOAD_BITS-1:0] din_leaf_user2interface_1,
   output logic [PAYLOAD_BITS-1:0] din_leaf_user2interface_2,
   output logic                    vld_user2interface_1,
   output logic                    vld_user2interface_2,
   input  logic                    ack_interface2user_1,
   input  logic                    ack_interface2user_2
);
   localparam int W = PAYLOAD_BITS;
   localparam logic [15:0] LAST_PAIR = 16'(FRAME_LEN - 1);

   if (FRAME_LEN < 1 || FRAME_LEN > 65535) begin : g_bad_frame_len
      $error("user_pair_alu: FRAME_LEN out of range 1..65535");
   end
   if (OUT_DEPTH < 2 || (OUT_DEPTH & (OUT_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("user_pair_alu: OUT_DEPTH must be a power of 2 and at least 2");
   end
   if (W < 32) begin : g_bad_width
      $error("user_pair_alu: PAYLOAD_BITS must hold the 32-bit trailer word");
   end

   typedef enum logic {RUN, TRAIL} state_t;

   state_t        state;
   state_t        state_next;
   logic [15:0]   pair_cnt;
   logic [15:0]   frame_idx;
   logic [W-1:0]  chk;

   logic          fire;
   logic          trail_push;
   logic          push;
   logic          room_1;
   logic          room_2;
   logic [W-1:0]  sum_res;
   logic [W-1:0]  diff_res;
   logic [W-1:0]  push_data_1;
   logic [W-1:0]  push_data_2;

   wire [W-1:0] op_a = dout_leaf_interface2user_1;
   wire [W-1:0] op_b = dout_leaf_interface2user_2;

`ifdef USER_PAIR_ALU_SAT_EN
   localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};
   logic [W-1:0] sum_wrap;
   logic [W-1:0] diff_wrap;

   // Overflow is only possible when the operand signs make the true result leave the signed range.
   always_comb begin
      sum_wrap  = op_a + op_b;
      diff_wrap = op_a - op_b;
      sum_res   = sum_wrap;
      diff_res  = diff_wrap;
      if (op_a[W-1] == op_b[W-1] && sum_wrap[W-1] != op_a[W-1])
         sum_res = op_a[W-1] ? SAT_MIN : SAT_MAX;
      if (op_a[W-1] != op_b[W-1] && diff_wrap[W-1] != op_a[W-1])
         diff_res = op_a[W-1] ? SAT_MIN : SAT_MAX;
   end
`else
   assign sum_res  = op_a + op_b;
   assign diff_res = op_a - op_b;
`endif

   always_ff @(posedge clk_user or posedge reset) begin
      if (reset) state <= RUN;
      else       state <= state_next;
   end

   // NOTE: combinational blocks use blocking '=' and assign every output first, so no latch is inferred.
   always_comb begin
      state_next = state;
      fire       = 1'b0;
      trail_push = 1'b0;
      case (state)
         RUN: begin
            if (vld_interface2user_1 && vld_interface2user_2 && room_1 && room_2) begin
               fire = 1'b1;
               if (pair_cnt == LAST_PAIR) state_next = TRAIL;
            end
         end
         TRAIL: begin
            if (room_1 && room_2) begin
               trail_push = 1'b1;
               state_next = RUN;
            end
         end
         default: state_next = RUN;
      endcase
   end

   assign ack_user2interface_1 = fire;
   assign ack_user2interface_2 = fire;
   assign push        = fire | trail_push;
   assign push_data_1 = fire ? sum_res  : W'({16'hA5A5, frame_idx});
   assign push_data_2 = fire ? diff_res : chk;

   // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
   always_ff @(posedge clk_user or posedge reset) begin
      if (reset) begin
         pair_cnt  <= '0;
         frame_idx <= '0;
         chk       <= '0;
      end else if (fire) begin
         pair_cnt <= pair_cnt + 1'b1;
         chk      <= chk ^ sum_res;
      end else if (trail_push) begin
         pair_cnt  <= '0;
         chk       <= '0;
         frame_idx <= frame_idx + 1'b1;
      end
   end

   user_pair_alu_fifo #(.WIDTH(W), .DEPTH(OUT_DEPTH)) u_fifo_1 (
      .clk       (clk_user),
      .rst       (reset),
      .push      (push),
      .push_data (push_data_1),
      .ack       (ack_interface2user_1),
      .data      (din_leaf_user2interface_1),
      .vld       (vld_user2interface_1),
      .room      (room_1)
   );

   user_pair_alu_fifo #(.WIDTH(W), .DEPTH(OUT_DEPTH)) u_fifo_2 (
      .clk       (clk_user),
      .rst       (reset),
      .push      (push),
      .push_data (push_data_2),
      .ack       (ack_interface2user_2),
      .data      (din_leaf_user2interface_2),
      .vld       (vld_user2interface_2),
      .room      (room_2)
   );
endmodule

// File: tb/tb_user_pair_alu.sv
// Self-checking bench for user_pair_alu: queue-based reference model plus directed literal sequences.
// Built with FRAME_LEN=2 and OUT_DEPTH=2 so trailers and backpressure appear quickly.

module tb_user_pair_alu;
   localparam int FRAME_LEN = 2;
   localparam int OUT_DEPTH = 2;

   typedef logic [31:0] word_q_t[$];

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        va = 1'b0;
   logic        vb = 1'b0;
   logic        oa1 = 1'b0;
   logic        oa2 = 1'b0;
   logic        ack1;
   logic        ack2;
   logic [31:0] dout1;
   logic [31:0] dout2;
   logic        ov1;
   logic        ov2;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   word_q_t     m_q1;
   word_q_t     m_q2;
   logic [31:0] m_chk;
   int          m_cnt;
   int          m_idx;
   bit          m_trail;
   // Accepted output words, recorded for directed sequence checks
   word_q_t     got1;
   word_q_t     got2;

   always #5 clk = ~clk;

   user_pair_alu #(.PAYLOAD_BITS(32), .FRAME_LEN(FRAME_LEN), .OUT_DEPTH(OUT_DEPTH)) dut (
      .clk_user                   (clk),
      .reset                      (reset),
      .dout_leaf_interface2user_1 (a),
      .dout_leaf_interface2user_2 (b),
      .vld_interface2user_1       (va),
      .vld_interface2user_2       (vb),
      .ack_user2interface_1       (ack1),
      .ack_user2interface_2       (ack2),
      .din_leaf_user2interface_1  (dout1),
      .din_leaf_user2interface_2  (dout2),
      .vld_user2interface_1       (ov1),
      .vld_user2interface_2       (ov2),
      .ack_interface2user_1       (oa1),
      .ack_interface2user_2       (oa2)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic check_seq(input string name, input int which, input int mark, input word_q_t exp);
      int n;
      n = ((which == 1) ? got1.size() : got2.size()) - mark;
      check({name, "_len"}, 32'(n), 32'(exp.size()));
      for (int i = 0; i < exp.size() && i < n; i++)
         check(name, (which == 1) ? got1[mark + i] : got2[mark + i], exp[i]);
   endtask

   // Signed 32-bit add/sub from plain integer arithmetic, optionally clamped.
   function automatic logic [31:0] model_op(input logic [31:0] x, input logic [31:0] y, input bit sub);
      longint r;
      longint hi;
      longint lo;
      hi = (longint'(1) <<< 31) - 1;
      lo = -(longint'(1) <<< 31);
      r = sub ? (longint'($signed(x)) - longint'($signed(y)))
              : (longint'($signed(x)) + longint'($signed(y)));
`ifdef USER_PAIR_ALU_SAT_EN
      if (r > hi) r = hi;
      if (r < lo) r = lo;
`else
      if (r > hi || r < lo) r = r;
`endif
      return r[31:0];
   endfunction

   // Compare process: at each falling edge check outputs, then advance the model to the next rising edge.
   always @(negedge clk) begin : compare
      bit          room1;
      bit          room2;
      bit          fire;
      logic [31:0] s;
      if (reset) begin
         check("rst_vld1", {31'd0, ov1}, 32'd0);
         check("rst_vld2", {31'd0, ov2}, 32'd0);
         check("rst_ack", {30'd0, ack1, ack2}, 32'd0);
         check("rst_din1", dout1, 32'd0);
         check("rst_din2", dout2, 32'd0);
         m_q1.delete();
         m_q2.delete();
         m_chk   = '0;
         m_cnt   = 0;
         m_idx   = 0;
         m_trail = 1'b0;
      end else begin
         room1 = (m_q1.size() < OUT_DEPTH) || (oa1 && m_q1.size() > 0);
         room2 = (m_q2.size() < OUT_DEPTH) || (oa2 && m_q2.size() > 0);
         fire  = !m_trail && va && vb && room1 && room2;
         check("cmp_ack1", {31'd0, ack1}, {31'd0, fire});
         check("cmp_ack2", {31'd0, ack2}, {31'd0, fire});
         check("cmp_vld1", {31'd0, ov1}, {31'd0, m_q1.size() != 0});
         check("cmp_vld2", {31'd0, ov2}, {31'd0, m_q2.size() != 0});
         if (m_q1.size() != 0) check("cmp_din1", dout1, m_q1[0]);
         if (m_q2.size() != 0) check("cmp_din2", dout2, m_q2[0]);
         if (ov1 && oa1) got1.push_back(dout1);
         if (ov2 && oa2) got2.push_back(dout2);
         if (oa1 && m_q1.size() != 0) void'(m_q1.pop_front());
         if (oa2 && m_q2.size() != 0) void'(m_q2.pop_front());
         if (fire) begin
            s = model_op(a, b, 1'b0);
            m_q1.push_back(s);
            m_q2.push_back(model_op(a, b, 1'b1));
            m_chk = m_chk ^ s;
            m_cnt++;
            if (m_cnt == FRAME_LEN) m_trail = 1'b1;
         end else if (m_trail && room1 && room2) begin
            m_q1.push_back({16'hA5A5, 16'(m_idx)});
            m_q2.push_back(m_chk);
            m_chk   = '0;
            m_cnt   = 0;
            m_idx   = (m_idx + 1) % 65536;
            m_trail = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      va = 1'b0;
      vb = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
   endtask

   // Present a pair and wait (bounded) for the joint ack; returns 1 ns after the accepting edge.
   task automatic send_pair(input logic [31:0] x, input logic [31:0] y);
      bit seen;
      seen = 1'b0;
      a = x;
      b = y;
      va = 1'b1;
      vb = 1'b1;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (ack1 && ack2) seen = 1'b1;
      end
      check("send_pair_ack", {31'd0, seen}, 32'd1);
      tick();
      va = 1'b0;
      vb = 1'b0;
   endtask

   initial begin : stimulus
      int mark1;
      int mark2;

      // Reset state
      @(negedge clk);
      check("reset_vld", {30'd0, ov1, ov2}, 32'd0);
      check("reset_ack", {30'd0, ack1, ack2}, 32'd0);
      tick();
      reset = 1'b0;
      oa1 = 1'b1;
      oa2 = 1'b1;

      // Basic pair: 5 + 3 and 5 - 3, latency 1, ack pulse of one cycle
      send_pair(32'd5, 32'd3);
      @(negedge clk);
      check("basic_ack_drop", {30'd0, ack1, ack2}, 32'd0);
      check("basic_vld", {30'd0, ov1, ov2}, 32'd3);
      check("basic_sum", dout1, 32'd8);
      check("basic_diff", dout2, 32'd2);
      @(negedge clk);
      check("basic_vld_one_cycle", {30'd0, ov1, ov2}, 32'd0);

      // Lone input waits without ack; completes the frame (trailer idx 0, chk 8^11)
      mark1 = got1.size();
      mark2 = got2.size();
      tick();
      a = 32'd10;
      va = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("lone_no_ack", {30'd0, ack1, ack2}, 32'd0);
      end
      tick();
      send_pair(32'd10, 32'd1);
      repeat (6) tick();
      check_seq("lone_out1", 1, mark1, '{32'd11, 32'hA5A50000});
      check_seq("lone_out2", 2, mark2, '{32'd9, 32'd3});

      // Backpressure: both output acks low, only OUT_DEPTH pairs accepted
      mark1 = got1.size();
      mark2 = got2.size();
      oa1 = 1'b0;
      oa2 = 1'b0;
      send_pair(32'd1, 32'd2);
      send_pair(32'd3, 32'd4);
      a = 32'd5;
      b = 32'd6;
      va = 1'b1;
      vb = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("bp_no_ack", {30'd0, ack1, ack2}, 32'd0);
      end
      check("bp_vld_held", {30'd0, ov1, ov2}, 32'd3);
      check("bp_head1", dout1, 32'd3);
      check("bp_head2", dout2, 32'hFFFFFFFF);
      tick();
      oa1 = 1'b1;
      oa2 = 1'b1;
      send_pair(32'd5, 32'd6);
      send_pair(32'd7, 32'd8);
      repeat (8) tick();
      check_seq("bp_out1", 1, mark1, '{32'd3, 32'd7, 32'hA5A50001, 32'd11, 32'd15, 32'hA5A50002});
      check_seq("bp_out2", 2, mark2, '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd4,
                                         32'hFFFFFFFF, 32'hFFFFFFFF, 32'd4});

      // Frame trailer sequence from a fresh reset, two frames
      do_reset();
      mark1 = got1.size();
      mark2 = got2.size();
      send_pair(32'd1, 32'd1);
      send_pair(32'd2, 32'd2);
      send_pair(32'd3, 32'd3);
      send_pair(32'd4, 32'd4);
      repeat (6) tick();
      check_seq("frame_out1", 1, mark1, '{32'd2, 32'd4, 32'hA5A50000, 32'd6, 32'd8, 32'hA5A50001});
      check_seq("frame_out2", 2, mark2, '{32'd0, 32'd0, 32'd6, 32'd0, 32'd0, 32'h0000000E});

      // Signed overflow corners
      mark1 = got1.size();
      mark2 = got2.size();
      send_pair(32'h7FFFFFFF, 32'd1);
      send_pair(32'h80000000, 32'd1);
      repeat (6) tick();
`ifdef USER_PAIR_ALU_SAT_EN
      check_seq("ovf_out1", 1, mark1, '{32'h7FFFFFFF, 32'h80000001, 32'hA5A50002});
      check_seq("ovf_out2", 2, mark2, '{32'h7FFFFFFE, 32'h80000000, 32'hFFFFFFFE});
`else
      check_seq("ovf_out1", 1, mark1, '{32'h80000000, 32'h80000001, 32'hA5A50002});
      check_seq("ovf_out2", 2, mark2, '{32'h7FFFFFFE, 32'h7FFFFFFF, 32'h00000001});
`endif

      // Reset mid-frame with output pending: vld drops at once, frame restarts at index 0
      oa1 = 1'b0;
      oa2 = 1'b0;
      send_pair(32'd9, 32'd1);
      check("midrst_pending", {30'd0, ov1, ov2}, 32'd3);
      reset = 1'b1;
      #1;
      check("midrst_vld_drop", {30'd0, ov1, ov2}, 32'd0);
      check("midrst_din1", dout1, 32'd0);
      tick();
      tick();
      reset = 1'b0;
      oa1 = 1'b1;
      oa2 = 1'b1;
      mark1 = got1.size();
      mark2 = got2.size();
      send_pair(32'd1, 32'd2);
      send_pair(32'd3, 32'd4);
      repeat (6) tick();
      check_seq("midrst_out1", 1, mark1, '{32'd3, 32'd7, 32'hA5A50000});
      check_seq("midrst_out2", 2, mark2, '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd4});

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
